deferred_control: RTL and testbench



---
 rtl/difftest_pkg.sv | 33 +++
 rtl/deferred_step_accumulator.sv | 57 +++++
 rtl/deferred_control.sv | 59 +++++
 tb/tb_deferred_control.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/difftest_pkg.sv
// difftest_pkg: shared definitions for the difftest step/result path.
//   SIMV_* codes      : verdict values presented on simv_result
//   DEFAULT_STEP_WIDTH: default width of the per-cycle commit step count
//   simv_nstep_batch  : advances the software checker by n instructions and
//                       returns 0 (running), 1 (DONE) or 2 (FAIL).
// A behavioural checker is compiled in. Its replies are programmable, and it
// records how many batches it was handed and the size of the most recent one.
package difftest_pkg;

    localparam logic [7:0] SIMV_RUNNING = 8'h00;
    localparam logic [7:0] SIMV_DONE    = 8'h01;
    localparam logic [7:0] SIMV_FAIL    = 8'h02;

    localparam int DEFAULT_STEP_WIDTH = 8;

    // Behavioural checker. Call number stub_special_call returns
    // stub_special_reply; every other call returns stub_default_reply.
    int unsigned stub_calls         = 0;
    int unsigned stub_last_n        = 0;
    int unsigned stub_special_call  = 0;
    byte         stub_special_reply = 0;
    byte         stub_default_reply = 0;

    function automatic byte simv_nstep_batch(input int unsigned n);
        stub_calls  = stub_calls + 1;
        stub_last_n = n;
        if (stub_calls == stub_special_call) begin
            return stub_special_reply;
        end
        return stub_default_reply;
    endfunction

endpackage

// File: rtl/deferred_step_accumulator.sv
// deferred_step_accumulator: batches per-cycle commit step counts.
//   clock       : simulation clock
//   reset       : synchronous, active-high reset
//   step        : instructions committed this cycle
//   flush_valid : a non-empty batch must be handed to the checker at this edge
//   flush_count : batch size (pending count plus this cycle's step)
// A flush happens every FETCH_INTERVAL cycles, or earlier once the batch
// reaches MAX_BATCH. The first cycle after reset is the endpoint's init
// cycle: the step input is ignored and nothing is accumulated.
module deferred_step_accumulator
    import difftest_pkg::*;
#(
    parameter int STEP_WIDTH     = DEFAULT_STEP_WIDTH,
    parameter int FETCH_INTERVAL = 5000,
    parameter int MAX_BATCH      = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [STEP_WIDTH-1:0] step,
    output logic                  flush_valid,
    output logic [31:0]           flush_count
);

    logic [31:0] acc;
    logic [31:0] timer;
    logic        first;
    logic [31:0] nxt;
    logic        flush;

    // This cycle's step is folded into the batch before the flush decision,
    // so a step that arrives in the flush cycle is not lost or counted twice.
    always_comb begin
        nxt   = acc + 32'(step);
        flush = (timer == 32'(FETCH_INTERVAL - 1)) || (nxt >= 32'(MAX_BATCH));
    end

    assign flush_valid = !reset && !first && flush && (nxt != 32'd0);
    assign flush_count = nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc   <= 32'd0;
            timer <= 32'd0;
            first <= 1'b1;
        end else if (first) begin
            first <= 1'b0;
        end else if (flush) begin
            // An empty flush still restarts the interval.
            acc   <= 32'd0;
            timer <= 32'd0;
        end else begin
            acc   <= nxt;
            timer <= timer + 32'd1;
        end
    end

endmodule

// File: rtl/deferred_control.sv
// deferred_control: deferred difftest step/result controller.
//   clock       : simulation clock
//   reset       : synchronous, active-high reset
//   step        : instructions committed this cycle (0 = none)
//   simv_result : registered checker verdict (0 running, 1 DONE, 2 FAIL)
// Commit steps are batched and handed to the checker in one call per flush.
// The call is made inside the clock edge, and its verdict is registered.
// DONE lasts one cycle. FAIL is sticky and stops further checker calls
// until reset.
module deferred_control
    import difftest_pkg::*;
#(
    parameter int STEP_WIDTH     = DEFAULT_STEP_WIDTH,
    parameter int FETCH_INTERVAL = 5000,
    parameter int MAX_BATCH      = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [STEP_WIDTH-1:0] step,
    output logic [7:0]            simv_result
);

    logic        flush_valid;
    logic [31:0] flush_count;

    deferred_step_accumulator #(
        .STEP_WIDTH    (STEP_WIDTH),
        .FETCH_INTERVAL(FETCH_INTERVAL),
        .MAX_BATCH     (MAX_BATCH)
    ) u_accumulator (
        .clock      (clock),
        .reset      (reset),
        .step       (step),
        .flush_valid(flush_valid),
        .flush_count(flush_count)
    );

    // Any reply outside the known codes is treated as a failure.
    function automatic logic [7:0] map_verdict(input byte reply);
        case (reply)
            8'sd0:   return SIMV_RUNNING;
            8'sd1:   return SIMV_DONE;
            default: return SIMV_FAIL;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            simv_result <= SIMV_RUNNING;
        end else if (flush_valid && (simv_result != SIMV_FAIL)) begin
            simv_result <= map_verdict(simv_nstep_batch(flush_count));
        end else if (simv_result == SIMV_DONE) begin
            // Drop DONE after one cycle; accumulation has already restarted
            // from an empty batch, so a new workload can continue.
            simv_result <= SIMV_RUNNING;
        end
    end

endmodule

// File: tb/tb_deferred_control.sv
// tb_deferred_control: directed and randomized bench for deferred_control.
// A cycle-level reference model tracks the pending batch, the number of
// cycles since the last flush, the expected checker calls and the verdict.
module tb_deferred_control;

    localparam int SW = 8;
    localparam int FI = 10;
    localparam int MB = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic [SW-1:0] step;
    logic [7:0]    simv_result;

    deferred_control #(
        .STEP_WIDTH    (SW),
        .FETCH_INTERVAL(FI),
        .MAX_BATCH     (MB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .step       (step),
        .simv_result(simv_result)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference model state.
    bit          m_first   = 1'b1;
    int unsigned m_pending = 0;
    int unsigned m_since   = 0;
    int unsigned m_calls   = 0;
    int unsigned m_last_n  = 0;
    logic [7:0]  m_result  = 8'h00;
    int unsigned done_cycles = 0;

    // Checker reply programme, mirrored into the package checker.
    int unsigned sp_call  = 0;
    byte         sp_reply = 0;
    byte         def_reply = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_stub(input int unsigned call_no, input byte reply, input byte dflt);
        sp_call   = call_no;
        sp_reply  = reply;
        def_reply = dflt;
        difftest_pkg::stub_special_call  = call_no;
        difftest_pkg::stub_special_reply = reply;
        difftest_pkg::stub_default_reply = dflt;
    endtask

    function automatic logic [7:0] verdict_of(input byte r);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'h01;
        return 8'h02;
    endfunction

    // One clock edge of expected behaviour.
    task automatic model_edge(input logic r, input int unsigned s);
        bit called;
        called = 1'b0;
        if (r) begin
            m_first   = 1'b1;
            m_pending = 0;
            m_since   = 0;
            m_result  = 8'h00;
            return;
        end
        if (m_first) begin
            m_first = 1'b0;
            return;
        end
        m_pending = m_pending + s;
        m_since   = m_since + 1;
        if (m_since == FI || m_pending >= MB) begin
            if (m_pending != 0 && m_result != 8'h02) begin
                m_calls  = m_calls + 1;
                m_last_n = m_pending;
                m_result = verdict_of((m_calls == sp_call) ? sp_reply : def_reply);
                called   = 1'b1;
            end
            m_pending = 0;
            m_since   = 0;
        end
        if (!called && m_result == 8'h01) m_result = 8'h00;
    endtask

    // Drive one cycle from the falling edge, then check at the next falling edge.
    task automatic tick(input logic r, input int unsigned s);
        int unsigned calls_before;
        reset = r;
        step  = SW'(s);
        calls_before = m_calls;
        model_edge(r, 32'(step));
        @(posedge clock);
        @(negedge clock);
        if (simv_result == 8'h01) done_cycles++;
        check("simv_result", 32'(simv_result), 32'(m_result));
        check("call_count", difftest_pkg::stub_calls, m_calls);
        if (m_calls != calls_before) check("batch_n", difftest_pkg::stub_last_n, m_last_n);
    endtask

    initial begin
        int unsigned snap;
        int unsigned s;
        logic        r;

        set_stub(0, 0, 0);

        // Reset with a nonzero step: no calls, verdict running.
        repeat (3) tick(1'b1, 5);
        check("reset_calls", difftest_pkg::stub_calls, 0);
        check("reset_result", 32'(simv_result), 0);

        // Init cycle ignores the step, then unit steps flush every FI cycles.
        tick(1'b0, 9);
        repeat (30) tick(1'b0, 1);
        check("unit_calls", difftest_pkg::stub_calls, 3);
        check("unit_n", difftest_pkg::stub_last_n, 10);

        // Step of 7 reaches MAX_BATCH on every third cycle with n=21.
        repeat (9) tick(1'b0, 7);
        check("batch_calls", difftest_pkg::stub_calls, 6);
        check("batch_n_21", difftest_pkg::stub_last_n, 21);

        // Second call of this phase returns DONE: a single-cycle pulse.
        set_stub(m_calls + 2, 1, 0);
        done_cycles = 0;
        repeat (9) tick(1'b0, 7);
        check("done_pulse_cycles", done_cycles, 1);
        check("after_done_n", difftest_pkg::stub_last_n, 21);

        // Idle for three intervals: no calls; the interval keeps restarting.
        snap = difftest_pkg::stub_calls;
        repeat (3 * FI) tick(1'b0, 0);
        check("idle_calls", difftest_pkg::stub_calls, snap);
        repeat (6) tick(1'b0, 3);
        check("post_idle_n", difftest_pkg::stub_last_n, 18);

        // FAIL is sticky and stops further calls.
        set_stub(m_calls + 1, 2, 0);
        snap = difftest_pkg::stub_calls;
        tick(1'b0, 20);
        repeat (50) tick(1'b0, $urandom_range(0, 20));
        check("fail_held", 32'(simv_result), 2);
        check("fail_no_calls", difftest_pkg::stub_calls, snap + 1);

        // Reset clears FAIL.
        repeat (2) tick(1'b1, 5);
        check("fail_cleared", 32'(simv_result), 0);
        set_stub(0, 0, 0);

        // Randomized traffic with occasional resets and DONE replies.
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) set_stub(m_calls + 1 + $urandom_range(0, 2), 1, 0);
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3);
            tick(r, s);
        end

        // An unknown reply code is treated as FAIL.
        set_stub(m_calls + 1, 7, 0);
        tick(1'b0, 0);
        tick(1'b0, 200);
        repeat (20) tick(1'b0, $urandom_range(0, 255));
        check("unknown_reply_fail", 32'(simv_result), 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
